change_dispense_ctrl: RTL

Sequencer for the vending machine's change-return path. On a start request it latches the paid and price values, computes the change (paid - price, clamped to 0), then dispenses it greedily as 5/2/1-unit coins to the coin hopper with a valid/ack handshake. It sits between the vend FSM, which issues start and receives done, and the coin hopper interface.

---
 rtl/change_dispense_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/change_dispense_ctrl.sv
// Change-return sequencer: computes paid - price and dispenses it greedily as 5/2/1 coins
// over a valid/ack handshake. Define CHANGE_TIMEOUT_EN to enable the coin_ack timeout and fault flag.
module change_dispense_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] paid,
    input  logic [3:0] price,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    output logic [4:0] change_left,
    output logic       busy,
    output logic       done,
    output logic       insufficient,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        SELECT,
        OFFER,
        DONE
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    state_t     state;
    logic [4:0] paid_reg;
    logic [3:0] price_reg;
    logic       short_reg;

`ifdef CHANGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_reg;

    assign fault = fault_reg;
`else
    // The timeout length is irrelevant here; fold it into a constant-zero flag.
    localparam bit TIMEOUT_SET = (TIMEOUT_CYCLES != 0);
    assign fault = 1'b0 & TIMEOUT_SET;
`endif

    function automatic logic [1:0] pick_coin(input logic [4:0] amount);
        if (amount >= 5'd5)
            return COIN_5;
        else if (amount >= 5'd2)
            return COIN_2;
        else
            return COIN_1;
    endfunction

    function automatic logic [4:0] coin_value(input logic [1:0] ctype);
        case (ctype)
            COIN_1:  return 5'd1;
            COIN_2:  return 5'd2;
            COIN_5:  return 5'd5;
            default: return 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            paid_reg     <= '0;
            price_reg    <= '0;
            short_reg    <= 1'b0;
            coin_valid   <= 1'b0;
            coin_type    <= COIN_NONE;
            change_left  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            insufficient <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
            wait_cnt     <= '0;
            fault_reg    <= 1'b0;
`endif
        end else begin
            done         <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        paid_reg  <= paid;
                        price_reg <= price;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end

                CALC: begin
                    if (paid_reg >= {1'b0, price_reg}) begin
                        change_left <= paid_reg - {1'b0, price_reg};
                        short_reg   <= 1'b0;
                    end else begin
                        change_left <= '0;
                        short_reg   <= 1'b1;
                    end
                    state <= SELECT;
                end

                SELECT: begin
                    if (change_left == 5'd0) begin
                        done         <= 1'b1;
                        insufficient <= short_reg;
                        state        <= DONE;
                    end else begin
                        coin_type  <= pick_coin(change_left);
                        coin_valid <= 1'b1;
                        state      <= OFFER;
                    end
                end

                OFFER: begin
                    // Greedy choice never exceeds change_left, so the subtraction cannot wrap.
                    if (coin_valid && coin_ack) begin
                        change_left <= change_left - coin_value(coin_type);
                        coin_valid  <= 1'b0;
                        coin_type   <= COIN_NONE;
                        state       <= SELECT;
`ifdef CHANGE_TIMEOUT_EN
                        wait_cnt    <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        coin_valid   <= 1'b0;
                        coin_type    <= COIN_NONE;
                        fault_reg    <= 1'b1;
                        wait_cnt     <= '0;
                        done         <= 1'b1;
                        insufficient <= short_reg;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                DONE: begin
                    short_reg <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    coin_valid <= 1'b0;
                    coin_type  <= COIN_NONE;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
